// File: rtl/shifter_74299.sv
// ============================================================================
// Module   : shifter_74299
// Purpose  : 74LS299 8-bit universal shift/storage register, cen-edge driven.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shifter_74299 (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       cen,
    input  logic       clr_n,
    input  logic [1:0] s,
    input  logic       oe1_n,
    input  logic       oe2_n,
    input  logic       ds0,
    input  logic       ds7,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       q_oe,
    output logic       qa_s,
    output logic       qh_s
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [7:0] reg8;
    logic       last_cen;
    logic       cen_edge;

    assign cen_edge = cen & ~last_cen;

    // last_cen resets high so a cen already high at reset release is not an edge
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            reg8     <= 8'h00;
            last_cen <= 1'b1;
        end else begin
            last_cen <= cen;
            if (!clr_n) begin
                reg8 <= 8'h00;
            end else if (cen_edge) begin
                case (s)
                    MODE_HOLD:  reg8 <= reg8;
                    MODE_RIGHT: reg8 <= {reg8[6:0], ds0};
                    MODE_LEFT:  reg8 <= {ds7, reg8[7:1]};
                    MODE_LOAD:  reg8 <= d;
                    default:    reg8 <= reg8;
                endcase
            end
        end
    end

    // Load mode turns the I/O pins around to inputs
    assign q_oe = ~oe1_n & ~oe2_n & ~(s[1] & s[0]);
    assign q    = q_oe ? reg8 : 8'h00;
    assign qa_s = reg8[0];
    assign qh_s = reg8[7];

endmodule

`default_nettype wire

// File: tb/tb_shifter_74299.sv
// Testbench for shifter_74299: directed vector table plus randomized run
// against a behavioural model of the register.
`default_nettype none

module tb_shifter_74299;

    logic       clk = 1'b0;
    logic       Reset_n, cen, clr_n, oe1_n, oe2_n, ds0, ds7;
    logic [1:0] s;
    logic [7:0] d;
    logic [7:0] q;
    logic       q_oe, qa_s, qh_s;

    int pass_cnt  = 0;
    int total_cnt = 0;

    shifter_74299 dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .cen     (cen),
        .clr_n   (clr_n),
        .s       (s),
        .oe1_n   (oe1_n),
        .oe2_n   (oe2_n),
        .ds0     (ds0),
        .ds7     (ds7),
        .d       (d),
        .q       (q),
        .q_oe    (q_oe),
        .qa_s    (qa_s),
        .qh_s    (qh_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cen;
        logic       clr_n;
        logic [1:0] s;
        logic       oe1_n;
        logic       oe2_n;
        logic       ds0;
        logic       ds7;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_oe;
        logic       exp_qa;
        logic       exp_qh;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: register value as an integer 0..255
    int m_val  = 0;
    bit m_prev = 1'b1;

    task automatic model_clock();
        if (!Reset_n) begin
            m_val  = 0;
            m_prev = 1'b1;
        end else begin
            bit rising;
            rising = cen && !m_prev;
            if (!clr_n)
                m_val = 0;
            else if (rising) begin
                if (s == 2'd1)      m_val = (m_val * 2 + int'(ds0)) % 256;
                else if (s == 2'd2) m_val = m_val / 2 + int'(ds7) * 128;
                else if (s == 2'd3) m_val = int'(d);
            end
            m_prev = cen;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_model(input string tag);
        logic       e_oe;
        logic [7:0] e_q;
        e_oe = !oe1_n && !oe2_n && (s != 2'd3);
        e_q  = e_oe ? 8'(m_val) : 8'h00;
        check({tag, "_q"},    q,           e_q);
        check({tag, "_oe"},   {7'd0, q_oe}, {7'd0, e_oe});
        check({tag, "_qa"},   {7'd0, qa_s}, {7'd0, 1'(m_val % 2)});
        check({tag, "_qh"},   {7'd0, qh_s}, {7'd0, 1'(m_val / 128)});
    endtask

    initial begin
        // cen, clr_n, s, oe1_n, oe2_n, ds0, ds7, d, exp_q, exp_oe, exp_qa, exp_qh
        tbl.push_back('{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h4B, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h4B, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h97, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h97, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h2F, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h52, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h52, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h29, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0});

        // Reset with cen high, load mode and d=FF on the pins
        Reset_n = 1'b0; cen = 1'b1; clr_n = 1'b1; s = 2'd3;
        oe1_n = 1'b0; oe2_n = 1'b0; ds0 = 1'b0; ds7 = 1'b0; d = 8'hFF;
        repeat (3) step();
        check("rst_q",  q,              8'h00);
        check("rst_oe", {7'd0, q_oe},   8'h00);
        check("rst_qa", {7'd0, qa_s},   8'h00);
        check("rst_qh", {7'd0, qh_s},   8'h00);
        s = 2'd0;
        #1;
        check("rst_oe_follows", {7'd0, q_oe}, 8'h01);
        s = 2'd3;

        // Release with cen still high: no false edge
        Reset_n = 1'b1;
        repeat (3) step();
        check("rel_qa", {7'd0, qa_s}, 8'h00);
        check("rel_qh", {7'd0, qh_s}, 8'h00);

        foreach (tbl[i]) begin
            cen   = tbl[i].cen;   clr_n = tbl[i].clr_n; s   = tbl[i].s;
            oe1_n = tbl[i].oe1_n; oe2_n = tbl[i].oe2_n; ds0 = tbl[i].ds0;
            ds7   = tbl[i].ds7;   d     = tbl[i].d;
            step();
            check($sformatf("vec%0d_q", i),  q,            tbl[i].exp_q);
            check($sformatf("vec%0d_oe", i), {7'd0, q_oe}, {7'd0, tbl[i].exp_oe});
            check($sformatf("vec%0d_qa", i), {7'd0, qa_s}, {7'd0, tbl[i].exp_qa});
            check($sformatf("vec%0d_qh", i), {7'd0, qh_s}, {7'd0, tbl[i].exp_qh});
        end

        // Randomized run against the model, including resets and clears
        Reset_n = 1'b0;
        step();
        for (int n = 0; n < 600; n++) begin
            Reset_n = ($urandom_range(0, 63) != 0);
            cen     = 1'($urandom_range(0, 1));
            clr_n   = ($urandom_range(0, 15) != 0);
            s       = 2'($urandom_range(0, 3));
            oe1_n   = ($urandom_range(0, 3) == 0);
            oe2_n   = ($urandom_range(0, 3) == 0);
            ds0     = 1'($urandom_range(0, 1));
            ds7     = 1'($urandom_range(0, 1));
            d       = 8'($urandom_range(0, 255));
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
